seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 33 +++
 rtl/seq_alu_core.sv | 86 ++++++++
 rtl/seq_alu.sv | 150 +++++++++++++++
 tb/tb_seq_alu.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode constants, FSM state
// encoding and the registered flag bundle.
// Optional multiply support is selected elsewhere by the SEQ_ALU_MUL_EN macro.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle for seq_alu.
// master: producer of operations and consumer of results (the environment).
// slave : the ALU itself.
//   in_valid/in_ready, op, a, b     -- operation channel
//   out_valid/out_ready, result,
//   z_flag, c_flag, v_flag          -- result channel
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             z_flag;
  logic             c_flag;
  logic             v_flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, z_flag, c_flag, v_flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, z_flag, c_flag, v_flag
  );

endinterface

// File: rtl/seq_alu_core.sv
// Combinational single-cycle ALU datapath.
// Ports:
//   i_op        operation code
//   i_a, i_b    operands
//   o_result_c  combinational result
//   o_flags_c   combinational {z, c, v}
// Opcode 111 evaluates as add here; the multiply path (SEQ_ALU_MUL_EN) lives
// in the top level.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_c,
  output flags_t           o_flags_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_v;
  logic             w_sub_v;
  logic             w_lt_u;
  logic             w_lt_s;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Extended arithmetic: the extra top bit is carry (add) or borrow (sub).
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_add_v = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
  assign w_sub_v = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
  assign w_lt_u  = (i_a < i_b);
  assign w_lt_s  = ($signed(i_a) < $signed(i_b));

  // Result/flag select; logical and compare ops never report carry/overflow.
  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    w_c   = w_sum[WIDTH];
    w_v   = w_add_v;
    case (i_op)
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_v;
      end
      OP_AND: begin
        w_res = i_a & i_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_OR: begin
        w_res = i_a | i_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_XOR: begin
        w_res = i_a ^ i_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_SLTU: begin
        w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_SLT: begin
        w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_result_c  = w_res;
  assign o_flags_c.z = (w_res == '0);
  assign o_flags_c.c = w_c;
  assign o_flags_c.v = w_v;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake, IDLE/BUSY/DONE FSM, optional iterative
// multiply and registered result/flags.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if.slave (operation and result channels)
// Macro SEQ_ALU_MUL_EN: op 111 becomes a WIDTH-cycle unsigned shift-add
// multiply; when undefined, op 111 behaves as add.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;
  logic             w_load_single;
  logic             w_load_mul;
  logic [WIDTH-1:0] w_core_result;
  flags_t           w_core_flags;
  logic [WIDTH-1:0] w_mul_result;
  flags_t           w_mul_flags;

  seq_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op       (bus.op),
    .i_a        (bus.a),
    .i_b        (bus.b),
    .o_result_c (w_core_result),
    .o_flags_c  (w_core_flags)
  );

  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_is_mul    = (bus.op == OP_MUL);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Final iteration's partial sum is the full product.
  assign w_load_mul    = (r_state == ST_BUSY) && w_last;
  assign w_mul_result  = w_prod_next[WIDTH-1:0];
  assign w_mul_flags.z = (w_prod_next[WIDTH-1:0] == '0);
  assign w_mul_flags.c = |w_prod_next[2*WIDTH-1:WIDTH];
  assign w_mul_flags.v = 1'b0;

  // Shift-add iteration: one multiplier bit consumed per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_prod   <= '0;
      r_mplier <= bus.b;
    end else if (r_state == ST_BUSY) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_mcand  <= r_mcand << 1;
      r_prod   <= w_prod_next;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_is_mul     = 1'b0;
  assign w_last       = 1'b1;
  assign w_load_mul   = 1'b0;
  assign w_mul_result = '0;
  assign w_mul_flags  = '0;
`endif

  assign w_load_single = w_accept && !w_is_mul;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; an accept in DONE overlaps the drain of the old result.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)          w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
        else if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output registers; held unchanged while a result waits on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      r_out_valid <= (w_state_next == ST_DONE);
      if (w_load_single) begin
        r_result <= w_core_result;
        r_flags  <= w_core_flags;
      end else if (w_load_mul) begin
        r_result <= w_mul_result;
        r_flags  <= w_mul_flags;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.z_flag    = r_flags.z;
  assign bus.c_flag    = r_flags.c;
  assign bus.v_flag    = r_flags.v;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=32 with hand-computed vectors.
// Multiply scenarios are compiled when SEQ_ALU_MUL_EN is defined; otherwise
// op 111 is checked as add.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {out_valid, result, z, c, v}
  function automatic logic [35:0] obs();
    return {bus.out_valid, bus.result, bus.z_flag, bus.c_flag, bus.v_flag};
  endfunction

  // Present one operation for one cycle; caller guarantees in_ready.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #2;
    n_tests++;
    if (obs() !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs(), 36'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ready: got %b want 1", bus.in_ready);
    end
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h8000_0000, 3'b001}) begin
      n_fail++;
      $display("FAIL add_overflow: got %h want %h", obs(), {1'b1, 32'h8000_0000, 3'b001});
    end
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h0000_0000, 3'b110}) begin
      n_fail++;
      $display("FAIL add_carry: got %h want %h", obs(), {1'b1, 32'h0000_0000, 3'b110});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    send(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'hFFFF_FFFF, 3'b010}) begin
      n_fail++;
      $display("FAIL sub_borrow: got %h want %h", obs(), {1'b1, 32'hFFFF_FFFF, 3'b010});
    end
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h7FFF_FFFF, 3'b001}) begin
      n_fail++;
      $display("FAIL sub_overflow: got %h want %h", obs(), {1'b1, 32'h7FFF_FFFF, 3'b001});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_compare();
    send(OP_SLT, 32'h8000_0000, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h0000_0001, 3'b000}) begin
      n_fail++;
      $display("FAIL slt: got %h want %h", obs(), {1'b1, 32'h0000_0001, 3'b000});
    end
    send(OP_SLTU, 32'h8000_0000, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h0000_0000, 3'b100}) begin
      n_fail++;
      $display("FAIL sltu: got %h want %h", obs(), {1'b1, 32'h0000_0000, 3'b100});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_logic();
    send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_tests++;
    if (obs() !== {1'b1, 32'hF000_F000, 3'b000}) begin
      n_fail++;
      $display("FAIL and: got %h want %h", obs(), {1'b1, 32'hF000_F000, 3'b000});
    end
    send(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_tests++;
    if (obs() !== {1'b1, 32'hFFF0_FFF0, 3'b000}) begin
      n_fail++;
      $display("FAIL or: got %h want %h", obs(), {1'b1, 32'hFFF0_FFF0, 3'b000});
    end
    send(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_tests++;
    if (obs() !== {1'b1, 32'h0FF0_0FF0, 3'b000}) begin
      n_fail++;
      $display("FAIL xor: got %h want %h", obs(), {1'b1, 32'h0FF0_0FF0, 3'b000});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.op = OP_ADD; bus.a = 32'd1; bus.b = 32'd2;
    @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== {1'b1, 32'd3, 3'b000} || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got %h rdy=%b want %h rdy=1", obs(), bus.in_ready, {1'b1, 32'd3, 3'b000});
    end
    bus.op = OP_SUB; bus.a = 32'd10; bus.b = 32'd3;
    @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== {1'b1, 32'd7, 3'b000}) begin
      n_fail++;
      $display("FAIL b2b_second: got %h want %h", obs(), {1'b1, 32'd7, 3'b000});
    end
    bus.op = OP_XOR; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (obs() !== {1'b1, 32'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL b2b_third: got %h want %h", obs(), {1'b1, 32'd0, 3'b100});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd5, 32'd6);
    bus.in_valid = 1'b1;
    bus.op = OP_OR; bus.a = 32'd1; bus.b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs() !== {1'b1, 32'd11, 3'b000} || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h rdy=%b want %h rdy=0", i, obs(), bus.in_ready, {1'b1, 32'd11, 3'b000});
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.result !== 32'd11) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b res=%h want 1 0000000b", bus.in_ready, bus.result);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (obs() !== {1'b1, 32'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_queued: got %h want %h", obs(), {1'b1, 32'd3, 3'b000});
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul();
    int cyc;
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (cyc != 33 || obs() !== {1'b1, 32'h0, 3'b110}) begin
      n_fail++;
      $display("FAIL mul_big: cyc=%0d got %h want cyc=33 %h", cyc, obs(), {1'b1, 32'h0, 3'b110});
    end
    @(posedge clk);
    #1;
    send(OP_MUL, 32'd7, 32'd6);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (cyc != 33 || obs() !== {1'b1, 32'd42, 3'b000}) begin
      n_fail++;
      $display("FAIL mul_small: cyc=%0d got %h want cyc=33 %h", cyc, obs(), {1'b1, 32'd42, 3'b000});
    end
    @(posedge clk);
    #1;
  endtask
`else
  task automatic test_mul();
    send(OP_MUL, 32'd7, 32'd6);
    n_tests++;
    if (obs() !== {1'b1, 32'd13, 3'b000}) begin
      n_fail++;
      $display("FAIL op7_as_add: got %h want %h", obs(), {1'b1, 32'd13, 3'b000});
    end
    send(OP_MUL, 32'h7FFF_FFFF, 32'h0000_0001);
    n_tests++;
    if (obs() !== {1'b1, 32'h8000_0000, 3'b001}) begin
      n_fail++;
      $display("FAIL op7_as_add_ovf: got %h want %h", obs(), {1'b1, 32'h8000_0000, 3'b001});
    end
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_reset_mid_op();
    int seen;
`ifdef SEQ_ALU_MUL_EN
    send(OP_MUL, 32'd7, 32'd6);
    repeat (5) @(posedge clk);
    #1;
`else
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want %h", obs(), 36'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_stale: out_valid cycles got %0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_logic();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
